wb_ctrl: RTL
============

Name: wb_ctrl

Overview:
- Writeback sequencer for the rysy core: accepts one decoded instruction per cycle and drives the rd-source mux select, register-file write enable and destination address.
- Sequences multi-cycle loads: holds the front end via `stall` until the data memory acknowledges.
- Supplies the registered PC+4 link value used as the RD_PCP4 mux input.
- Sits between decode and the rd mux / reg_file write port.

Parameters:
- REG_LEN, 32, datapath/register width.
- REG_ADR, 5, register address width.
- MEM_TIMEOUT, 15, maximum cycles waiting for `mem_ack` before abort (1..255).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  decoded instruction present this cycle.
- instr_class  in  3  0 NONE, 1 IMM (LUI), 2 LINK (JAL/JALR), 3 ALU, 4 LOAD; 5-7 treated as NONE.
- rd_addr_in  in  REG_ADR  destination register from decode.
- pc  in  REG_LEN  PC of the offered instruction.
- mem_ack  in  1  data memory has load data valid (single-cycle pulse).
- rd_sel  out  2  mux select: 00 IMM, 01 PCP4, 10 ALU, 11 MEM.
- rd_we  out  1  register-file write enable.
- rd_addr  out  REG_ADR  register-file write address.
- pc_link  out  REG_LEN  registered pc+4 for the RD_PCP4 input.
- mem_req  out  1  load outstanding.
- stall  out  1  front end must hold the current instruction.
- mem_err  out  1  one-cycle pulse on load timeout.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; rd_sel=00, rd_we=0, rd_addr=0, pc_link=0, mem_req=0, mem_err=0, timeout counter=0. Reset mid-load aborts with no write and no mem_err.
- States: IDLE, LOAD_WAIT.
- Outputs:
  - stall = (state==LOAD_WAIT), combinational from state only.
  - All other outputs are registered.
- Accept: the instruction is accepted when instr_valid=1 and stall=0.
- IDLE, accepted class IMM/LINK/ALU at edge N: from N+1 for one cycle, rd_sel = 00/01/10 respectively, rd_addr = rd_addr_in, rd_we = (rd_addr_in != 0). Back-to-back accepts give one write per cycle.
- LINK accept: pc_link <= pc + 4, modulo 2^REG_LEN (0xFFFFFFFC gives 0). pc_link is updated only on LINK accepts and holds otherwise.
- NONE, or no accept: rd_we=0 next cycle; rd_sel and rd_addr hold their previous values.
- IDLE, accepted LOAD at edge N:
  - state becomes LOAD_WAIT at N+1; mem_req=1 and rd_addr is latched; rd_we=0; counter cleared.
  - mem_ack is ignored in IDLE.
- LOAD_WAIT:
  - Counter increments each cycle.
  - mem_ack=1 at edge M: at M+1 rd_sel=11, rd_we = (latched addr != 0), mem_req=0, state IDLE. stall falls at M+1, so a new instruction can be accepted at edge M+1.
  - Counter reaching MEM_TIMEOUT without ack: next cycle mem_err=1 (one cycle), rd_we=0, mem_req=0, state IDLE.
  - mem_ack on the same edge the counter reaches MEM_TIMEOUT: ack wins, no error.
- Writes to x0 are never enabled. rd_sel is still driven so the mux remains deterministic.

Decomposition:
- Shared package rysy_pkg.vh holds:
  - REG_LEN and REG_ADR;
  - the RD_IMM/RD_PCP4/RD_ALU/RD_MEM select codes, moved from rd_mux so both blocks share one definition;
  - the instruction-class codes;
  - the FSM state codes.
- A sub-module `wb_timeout_cnt` (clear, enable, terminal-count flag, width from MEM_TIMEOUT) is natural. The FSM stays in wb_ctrl.

Test Plan:
- Reset: assert rst mid-LOAD_WAIT with mem_req=1 -> next cycle all outputs 0, stall=0, no mem_err.
- ALU stream: instr_class=3 with rd_addr_in=5,6,7 on consecutive cycles -> rd_we=1, rd_sel=10, rd_addr=5,6,7 one cycle later each; rd_addr_in=0 -> rd_we=0.
- LINK wrap: instr_class=2, pc=0x0000_0100 -> pc_link=0x0000_0104, rd_sel=01; pc=0xFFFF_FFFC -> pc_link=0x0000_0000.
- Load, ack after 3 cycles:
  - stimulus: LOAD to rd 9 at edge N.
  - response: stall and mem_req high for N+1..N+3; ack at edge N+3 -> at N+4 rd_we=1, rd_sel=11, rd_addr=9, stall=0.
  - An ALU instr offered during stall is accepted only at N+4 and is written at N+5.
- Timeout: LOAD with no ack, MEM_TIMEOUT=15 -> mem_err pulses exactly one cycle after 15 wait cycles, rd_we stays 0, state IDLE.
- Ack coincident with terminal count -> write occurs, mem_err=0.

Source files
------------

// File: rtl/rysy_pkg.sv
// Shared definitions for the rysy writeback path: datapath widths, rd mux
// select codes, decoded instruction classes and writeback FSM states.
package rysy_pkg;

   localparam int REG_LEN = 32;
   localparam int REG_ADR = 5;

   typedef enum logic [1:0] {
      RD_IMM  = 2'b00,
      RD_PCP4 = 2'b01,
      RD_ALU  = 2'b10,
      RD_MEM  = 2'b11
   } rd_sel_e;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_IMM  = 3'd1,
      CLS_LINK = 3'd2,
      CLS_ALU  = 3'd3,
      CLS_LOAD = 3'd4
   } instr_class_e;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Load-wait cycle counter: clears while idle, counts while enabled and flags
// the cycle on which the next increment would reach MEM_TIMEOUT.
module wb_timeout_cnt #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tc_o = (cnt_q == CW'(MEM_TIMEOUT - 1));

   // Saturate at the terminal value so a stuck enable can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + CW'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback sequencer: turns decoded instructions into rd mux select and
// register-file write controls, and holds the front end during loads.
module wb_ctrl
   import rysy_pkg::*;
#(
   parameter int REG_LEN     = rysy_pkg::REG_LEN,
   parameter int REG_ADR     = rysy_pkg::REG_ADR,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               instr_valid_i,
   input  logic [2:0]         instr_class_i,
   input  logic [REG_ADR-1:0] rd_addr_in_i,
   input  logic [REG_LEN-1:0] pc_i,
   input  logic               mem_ack_i,
   output logic [1:0]         rd_sel_o,
   output logic               rd_we_o,
   output logic [REG_ADR-1:0] rd_addr_o,
   output logic [REG_LEN-1:0] pc_link_o,
   output logic               mem_req_o,
   output logic               stall_o,
   output logic               mem_err_o
);

   wb_state_e          state_q,   state_d;
   logic [1:0]         rd_sel_q,  rd_sel_d;
   logic               rd_we_q,   rd_we_d;
   logic [REG_ADR-1:0] rd_addr_q, rd_addr_d;
   logic [REG_LEN-1:0] pc_link_q, pc_link_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_err_q, mem_err_d;
   logic               tc_s;

   wb_timeout_cnt #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timeout (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (state_q == ST_IDLE),
      .en_i  (state_q == ST_LOAD_WAIT),
      .tc_o  (tc_s)
   );

   // rd_sel/rd_addr hold unless a write source is selected; x0 is never written.
   always_comb begin
      state_d   = state_q;
      rd_sel_d  = rd_sel_q;
      rd_we_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      pc_link_d = pc_link_q;
      mem_req_d = 1'b0;
      mem_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid_i) begin
               case (instr_class_i)
                  CLS_IMM: begin
                     rd_sel_d  = RD_IMM;
                     rd_addr_d = rd_addr_in_i;
                     rd_we_d   = (rd_addr_in_i != '0);
                  end
                  CLS_LINK: begin
                     rd_sel_d  = RD_PCP4;
                     rd_addr_d = rd_addr_in_i;
                     rd_we_d   = (rd_addr_in_i != '0);
                     pc_link_d = pc_i + REG_LEN'(32'd4);
                  end
                  CLS_ALU: begin
                     rd_sel_d  = RD_ALU;
                     rd_addr_d = rd_addr_in_i;
                     rd_we_d   = (rd_addr_in_i != '0);
                  end
                  CLS_LOAD: begin
                     state_d   = ST_LOAD_WAIT;
                     rd_addr_d = rd_addr_in_i;
                     mem_req_d = 1'b1;
                  end
                  default: begin
                     rd_we_d = 1'b0;
                  end
               endcase
            end else begin
               rd_we_d = 1'b0;
            end
         end
         ST_LOAD_WAIT: begin
            // An ack on the terminal cycle still completes the load.
            if (mem_ack_i) begin
               state_d  = ST_IDLE;
               rd_sel_d = RD_MEM;
               rd_we_d  = (rd_addr_q != '0);
            end else if (tc_s) begin
               state_d   = ST_IDLE;
               mem_err_d = 1'b1;
            end else begin
               mem_req_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         rd_sel_q  <= RD_IMM;
         rd_we_q   <= 1'b0;
         rd_addr_q <= '0;
         pc_link_q <= '0;
         mem_req_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_sel_q  <= rd_sel_d;
         rd_we_q   <= rd_we_d;
         rd_addr_q <= rd_addr_d;
         pc_link_q <= pc_link_d;
         mem_req_q <= mem_req_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign stall_o   = (state_q == ST_LOAD_WAIT);
   assign rd_sel_o  = rd_sel_q;
   assign rd_we_o   = rd_we_q;
   assign rd_addr_o = rd_addr_q;
   assign pc_link_o = pc_link_q;
   assign mem_req_o = mem_req_q;
   assign mem_err_o = mem_err_q;

endmodule
